// File: rtl/mul_result_combine_pkg.sv
// Shared definitions for the multiply result combine block.
//   - HALF_W     : width of an operand half-word
//   - mul_op_e   : M_op encodings
//   - state_t    : combine FSM state constants (IDLE, HH, FIX)
package mul_result_combine_pkg;

  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,  // a signed, b unsigned
    OP_MULXSS = 2'd3
  } mul_op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HH   = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/mul_hh_shift_add.sv
// Iterative 16x16 unsigned multiplier used to form a_hi*b_hi.
// Retires HH_BITS_PER_CYCLE multiplier bits per cycle, MSB first, so the
// product is ready after 16/HH_BITS_PER_CYCLE iterations. Legal
// HH_BITS_PER_CYCLE values: 1, 2, 4.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load operands and begin (ignored while busy by contract)
//   mcand        : multiplicand (a_hi)
//   mplier       : multiplier (b_hi)
//   product      : accumulator; holds a_hi*b_hi once the last iteration ran
//   done         : high during the final iteration cycle; product is
//                  complete in the following cycle
module mul_hh_shift_add
  import mul_result_combine_pkg::*;
#(
  parameter int HH_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [HALF_W-1:0] mcand,
  input  logic [HALF_W-1:0] mplier,
  output logic [31:0]       product,
  output logic              done
);

  localparam int         K      = HH_BITS_PER_CYCLE;
  localparam logic [4:0] N_ITER = 5'(HALF_W / K);

  logic [31:0]       acc_q;
  logic [HALF_W-1:0] mcand_q;
  logic [HALF_W-1:0] mplier_q;
  logic [4:0]        count_q;   // iterations still to run; 0 = idle

  // Sum of mcand shifted by each set bit of a K-bit multiplier slice.
  function automatic logic [31:0] slice_product(input logic [K-1:0] bits,
                                                input logic [HALF_W-1:0] m);
    logic [31:0] sum;
    sum = '0;
    for (int j = 0; j < K; j++) begin
      if (bits[j]) sum = sum + ({16'h0, m} << j);
    end
    return sum;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= mcand;
      mplier_q <= mplier;
      count_q  <= N_ITER;
    end else if (count_q != 5'd0) begin
      // MSB-first: shift what we have, then add the next slice's product.
      acc_q    <= (acc_q << K) + slice_product(mplier_q[HALF_W-1 -: K], mcand_q);
      mplier_q <= mplier_q << K;
      count_q  <= count_q - 5'd1;
    end
  end

  assign product = acc_q;
  assign done    = (count_q == 5'd1);

endmodule

// File: rtl/mul_result_combine.sv
// A-stage multiply result combine.
// Builds the 32-bit result from the three partial products of the multiply
// cell: the low word (MUL) in one cycle, or the high word (MULX*) after an
// iterative a_hi*b_hi computation, stalling the pipeline meanwhile.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   M_mul_cell_p1/p2/p3   : a_lo*b_lo, a_lo*b_hi, a_hi*b_lo (unsigned)
//   M_src1, M_src2        : operands a, b
//   M_valid, M_op         : op present in M and its encoding (mul_op_e)
//   M_mul_stall           : upstream must hold M while high
//   A_mul_result          : result word, held between pulses
//   A_mul_result_valid    : one-cycle pulse marking a new result
module mul_result_combine
  import mul_result_combine_pkg::*;
#(
  parameter bit MULX_EN           = 1'b1,
  parameter int HH_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic        M_valid,
  input  logic [1:0]  M_op,
  output logic        M_mul_stall,
  output logic [31:0] A_mul_result,
  output logic        A_mul_result_valid
);

  state_t            state_q;
  logic              stall_q;
  logic [HALF_W-1:0] p1_hi_q;
  logic [31:0]       p2_q;
  logic [31:0]       p3_q;
  logic [31:0]       ca_q;
  logic [31:0]       cb_q;

  logic              accept;
  logic              is_mulx;
  logic              hh_start;
  logic              hh_done;
  logic [31:0]       hh_product;
  logic [15:0]       lo_mid;
  logic [31:0]       lo_word;
  logic [31:0]       ca;
  logic [31:0]       cb;
  logic [1:0]        mid_carry;
  logic [31:0]       hi_word;

  assign accept   = M_valid && (state_q == ST_IDLE);
  assign is_mulx  = MULX_EN && (M_op != OP_MUL);
  assign hh_start = accept && is_mulx;

  // Low word: only the low halves of p2/p3 land inside bits 31:0.
  assign lo_mid  = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign lo_word = M_mul_cell_p1 + {lo_mid, 16'h0};

  // Signed-operand correction: a negative a means the unsigned product
  // over-counts by b*2^32 (and vice versa for b); the 2^64 cross term
  // falls outside the 64-bit result.
  assign ca = (M_src1[31] && (M_op == OP_MULXSU || M_op == OP_MULXSS)) ? M_src2 : 32'h0;
  assign cb = (M_src2[31] && (M_op == OP_MULXSS)) ? M_src1 : 32'h0;

  // Carry out of bits 31:16 into the high word (can be 0..2).
  assign mid_carry = 2'(({2'b0, p1_hi_q} + {2'b0, p2_q[15:0]} + {2'b0, p3_q[15:0]}) >> 16);

  assign hi_word = hh_product + {16'h0, p2_q[31:16]} + {16'h0, p3_q[31:16]}
                 + {30'h0, mid_carry} - ca_q - cb_q;

  generate
    if (MULX_EN) begin : g_hh
      mul_hh_shift_add #(
        .HH_BITS_PER_CYCLE(HH_BITS_PER_CYCLE)
      ) u_hh (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (hh_start),
        .mcand  (M_src1[31:16]),
        .mplier (M_src2[31:16]),
        .product(hh_product),
        .done   (hh_done)
      );
    end else begin : g_no_hh
      assign hh_product = 32'h0;
      assign hh_done    = 1'b0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the capture registers are reset too, so an aborted MULX
      // leaves no stale operands behind.
      state_q            <= ST_IDLE;
      stall_q            <= 1'b0;
      p1_hi_q            <= '0;
      p2_q               <= '0;
      p3_q               <= '0;
      ca_q               <= '0;
      cb_q               <= '0;
      A_mul_result       <= '0;
      A_mul_result_valid <= 1'b0;
    end else begin
      A_mul_result_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mulx) begin
              p1_hi_q <= M_mul_cell_p1[31:16];
              p2_q    <= M_mul_cell_p2;
              p3_q    <= M_mul_cell_p3;
              ca_q    <= ca;
              cb_q    <= cb;
              stall_q <= 1'b1;
              state_q <= ST_HH;
            end else begin
              A_mul_result       <= lo_word;
              A_mul_result_valid <= 1'b1;
            end
          end
        end
        ST_HH: begin
          if (hh_done) state_q <= ST_FIX;
        end
        ST_FIX: begin
          A_mul_result       <= hi_word;
          A_mul_result_valid <= 1'b1;
          stall_q            <= 1'b0;
          state_q            <= ST_IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign M_mul_stall = MULX_EN ? stall_q : 1'b0;

endmodule

// File: tb/tb_mul_result_combine.sv
// Directed bench for mul_result_combine: one instance with the default
// one-bit-per-cycle high-word engine and one retiring four bits per cycle.
module tb_mul_result_combine;
  import mul_result_combine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] p1, p2, p3, src1, src2;
  logic [1:0]  op;
  logic        v1, v4;

  logic        stall1, rv1, stall4, rv4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_result_combine #(.MULX_EN(1'b1), .HH_BITS_PER_CYCLE(1)) dut1 (
    .clk               (clk),
    .reset_n           (reset_n),
    .M_mul_cell_p1     (p1),
    .M_mul_cell_p2     (p2),
    .M_mul_cell_p3     (p3),
    .M_src1            (src1),
    .M_src2            (src2),
    .M_valid           (v1),
    .M_op              (op),
    .M_mul_stall       (stall1),
    .A_mul_result      (res1),
    .A_mul_result_valid(rv1)
  );

  mul_result_combine #(.MULX_EN(1'b1), .HH_BITS_PER_CYCLE(4)) dut4 (
    .clk               (clk),
    .reset_n           (reset_n),
    .M_mul_cell_p1     (p1),
    .M_mul_cell_p2     (p2),
    .M_mul_cell_p3     (p3),
    .M_src1            (src1),
    .M_src2            (src2),
    .M_valid           (v4),
    .M_op              (op),
    .M_mul_stall       (stall4),
    .A_mul_result      (res4),
    .A_mul_result_valid(rv4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive operands plus the partial products the multiply cell would form.
  task automatic set_operands(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op   = o;
    src1 = a;
    src2 = b;
    p1   = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
    p2   = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
    p3   = {16'h0, a[31:16]} * {16'h0, b[15:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (caller sits 1 time unit after a rising edge), then track
  // latency, result, stall profile and pulse width.
  task automatic do_op(input string tag, input bit sel4, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    int   lat;
    int   stall_bad;
    logic [31:0] got;
    set_operands(o, a, b);
    if (sel4) v4 = 1'b1; else v1 = 1'b1;
    tick();
    v1 = 1'b0;
    v4 = 1'b0;
    lat       = 0;
    stall_bad = 0;
    got       = 'x;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      if (sel4 ? rv4 : rv1) begin
        lat = cyc;
        got = sel4 ? res4 : res1;
        check({tag, "_stall_at_valid"}, {31'h0, sel4 ? stall4 : stall1}, 32'h0);
      end else begin
        if ((sel4 ? stall4 : stall1) !== (o != OP_MUL)) stall_bad++;
        tick();
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, got, exp);
    check({tag, "_stall_profile"}, stall_bad, 0);
    tick();
    check({tag, "_pulse_width"}, {31'h0, sel4 ? rv4 : rv1}, 32'h0);
    check({tag, "_hold"}, sel4 ? res4 : res1, exp);
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0;
    v1 = 1'b0;
    v4 = 1'b0;
    set_operands(OP_MUL, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_result1", res1, 32'h0);
    check("rst_valid1",  {31'h0, rv1}, 32'h0);
    check("rst_stall1",  {31'h0, stall1}, 32'h0);
    check("rst_result4", res4, 32'h0);
    check("rst_stall4",  {31'h0, stall4}, 32'h0);
    reset_n = 1'b1;
    tick();

    do_op("mul",      1'b0, OP_MUL,    32'h00010003, 32'h00020005, 32'h000B000F, 1);
    do_op("mul_wrap", 1'b0, OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1);
    do_op("mulxuu",   1'b0, OP_MULXUU, 32'h00010003, 32'h00020005, 32'h00000002, 18);
    do_op("mulxss",   1'b0, OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 18);
    do_op("mulxsu",   1'b0, OP_MULXSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 18);
    do_op("mulxuu_ff", 1'b0, OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 18);

    // Back-to-back MULs: one result per cycle, no stall.
    set_operands(OP_MUL, 32'h00010003, 32'h00020005);
    v1 = 1'b1;
    tick();
    check("b2b_first_valid", {31'h0, rv1}, 32'h1);
    check("b2b_first", res1, 32'h000B000F);
    set_operands(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    v1 = 1'b0;
    check("b2b_second_valid", {31'h0, rv1}, 32'h1);
    check("b2b_second", res1, 32'h00000001);
    check("b2b_stall", {31'h0, stall1}, 32'h0);
    tick();
    check("b2b_end", {31'h0, rv1}, 32'h0);

    // Four bits per cycle: latency 6, same results.
    do_op("x4_mulxuu", 1'b1, OP_MULXUU, 32'h00010003, 32'h00020005, 32'h00000002, 6);
    do_op("x4_mulxss", 1'b1, OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6);
    do_op("x4_mulxsu", 1'b1, OP_MULXSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 6);

    // New op accepted in the same cycle the MULX result is valid.
    set_operands(OP_MULXUU, 32'h00010003, 32'h00020005);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    repeat (5) tick();
    check("overlap_mulx_valid", {31'h0, rv4}, 32'h1);
    check("overlap_mulx", res4, 32'h00000002);
    set_operands(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    check("overlap_mul_valid", {31'h0, rv4}, 32'h1);
    check("overlap_mul", res4, 32'h00000001);

    // Reset in the middle of a MULXUU: abort, no pulse afterwards.
    tick();
    set_operands(OP_MULXUU, 32'h00010003, 32'h00020005);
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (4) tick();
    check("abort_stall_before", {31'h0, stall1}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_stall", {31'h0, stall1}, 32'h0);
    check("abort_valid", {31'h0, rv1}, 32'h0);
    check("abort_result", res1, 32'h0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (rv1 || stall1) pulses++;
      tick();
    end
    check("abort_no_activity", pulses, 0);
    do_op("after_abort", 1'b0, OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
